// File: rtl/throw_sched.sv
`timescale 1ns/1ps
// throw_sched: alternates throws between local and remote player, launches the
// trajectory generator, resolves each throw (hit/land/timeout), keeps scores, enforces cooldown.
module throw_sched #(
  parameter int unsigned GROUND_Y     = 768,
  parameter int unsigned TIMEOUT_CYC  = 120_000_000,
  parameter int unsigned COOLDOWN_CYC = 6_000_000
) (
  input  logic        clk60MHz,
  input  logic        rst_n,
  input  logic        local_req,
  input  logic        remote_req,
  input  logic        hit,
  input  logic [11:0] ypos_prebuff,
  output logic        throw_flag,
  output logic        in_throw_flag,
  output logic        end_throw,
  output logic        turn,
  output logic        busy,
  output logic        result_valid,
  output logic        result_hit,
  output logic [3:0]  score_local,
  output logic [3:0]  score_remote
);

  typedef enum logic [2:0] {IDLE, LAUNCH, FLIGHT, END, COOLDOWN} state_t;

  localparam logic [11:0] GROUND      = 12'(GROUND_Y);
  localparam logic [26:0] FLIGHT_LAST = 27'(TIMEOUT_CYC - 1);
  localparam logic [26:0] COOL_LAST   = 27'(COOLDOWN_CYC - 1);
  localparam logic [3:0]  SCORE_MAX   = 4'd9;

  state_t      state, next_state;
  logic [26:0] cnt, cnt_nxt;
  logic        armed, armed_nxt;
  logic        end_seen, end_seen_nxt;
  logic        turn_nxt;
  logic [3:0]  score_local_nxt, score_remote_nxt;
  logic        result_valid_nxt, result_hit_nxt;
  logic        req, resolve;

  always_comb begin
    next_state       = state;
    cnt_nxt          = cnt;
    armed_nxt        = armed;
    end_seen_nxt     = end_seen;
    turn_nxt         = turn;
    score_local_nxt  = score_local;
    score_remote_nxt = score_remote;
    result_valid_nxt = 1'b0;
    result_hit_nxt   = 1'b0;
    req              = turn ? remote_req : local_req;
    resolve          = 1'b0;

    case (state)
      IDLE: begin
        if (req) next_state = LAUNCH;
      end
      LAUNCH: begin
        cnt_nxt    = '0;
        armed_nxt  = 1'b0;
        next_state = FLIGHT;
      end
      FLIGHT: begin
        cnt_nxt = cnt + 27'd1;
        if (ypos_prebuff < GROUND) armed_nxt = 1'b1;
        // A hit wins over landing and timeout; armed prevents a launch from ground counting as a landing
        resolve = hit || (armed && (ypos_prebuff >= GROUND)) || (cnt == FLIGHT_LAST);
        if (resolve) begin
          next_state       = END;
          end_seen_nxt     = 1'b0;
          result_valid_nxt = 1'b1;
          result_hit_nxt   = hit;
          if (hit && !turn && (score_local < SCORE_MAX))
            score_local_nxt = score_local + 4'd1;
          if (hit && turn && (score_remote < SCORE_MAX))
            score_remote_nxt = score_remote + 4'd1;
        end
      end
      END: begin
        // Generator only drops to ground once descending, so wait for it and a 2-cycle minimum
        end_seen_nxt = 1'b1;
        if (end_seen && (ypos_prebuff == GROUND)) begin
          next_state = COOLDOWN;
          cnt_nxt    = '0;
        end
      end
      COOLDOWN: begin
        cnt_nxt = cnt + 27'd1;
        if (cnt == COOL_LAST) begin
          next_state = IDLE;
          cnt_nxt    = '0;
          turn_nxt   = ~turn;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      armed         <= 1'b0;
      end_seen      <= 1'b0;
      turn          <= 1'b0;
      score_local   <= '0;
      score_remote  <= '0;
      result_valid  <= 1'b0;
      result_hit    <= 1'b0;
      throw_flag    <= 1'b0;
      in_throw_flag <= 1'b0;
      end_throw     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= next_state;
      cnt           <= cnt_nxt;
      armed         <= armed_nxt;
      end_seen      <= end_seen_nxt;
      turn          <= turn_nxt;
      score_local   <= score_local_nxt;
      score_remote  <= score_remote_nxt;
      result_valid  <= result_valid_nxt;
      result_hit    <= result_hit_nxt;
      throw_flag    <= (next_state == LAUNCH) && !turn;
      in_throw_flag <= (next_state == LAUNCH) && turn;
      end_throw     <= (next_state == END);
      busy          <= (next_state != IDLE);
    end
  end

endmodule

// File: tb/tb_throw_sched.sv
`timescale 1ns/1ps
// tb_throw_sched: directed stimulus with a queue scoreboard; a negedge monitor
// checks launch strobes and resolved results against bench-predicted values.
module tb_throw_sched;

  logic        clk60MHz = 1'b0;
  logic        rst_n;
  logic        local_req, remote_req, hit;
  logic [11:0] ypos;
  logic        throw_flag, in_throw_flag, end_throw, turn, busy, result_valid, result_hit;
  logic [3:0]  score_local, score_remote;

  int total = 0;
  int bad   = 0;

  logic [1:0] launch_q[$];
  logic [8:0] result_q[$];
  logic [3:0] sl_m = 4'd0;
  logic [3:0] sr_m = 4'd0;
  logic       prev_strobe = 1'b0;
  logic [1:0] exp_launch;
  logic [8:0] exp_res;

  always #8 clk60MHz = ~clk60MHz;

  throw_sched #(.GROUND_Y(768), .TIMEOUT_CYC(1000), .COOLDOWN_CYC(8)) dut (
    .clk60MHz(clk60MHz), .rst_n(rst_n), .local_req(local_req), .remote_req(remote_req),
    .hit(hit), .ypos_prebuff(ypos), .throw_flag(throw_flag), .in_throw_flag(in_throw_flag),
    .end_throw(end_throw), .turn(turn), .busy(busy), .result_valid(result_valid),
    .result_hit(result_hit), .score_local(score_local), .score_remote(score_remote)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: every strobe / result is matched against the next queued expectation
  always @(negedge clk60MHz) begin
    if (throw_flag || in_throw_flag) begin
      check("strobe_width", 32'(prev_strobe), 32'd0);
      if (launch_q.size() == 0)
        check("launch_unexpected", 32'({throw_flag, in_throw_flag}), 32'd0);
      else begin
        exp_launch = launch_q.pop_front();
        check("launch_kind", 32'({throw_flag, in_throw_flag}), 32'(exp_launch));
      end
    end
    prev_strobe = throw_flag | in_throw_flag;
    if (result_valid) begin
      if (result_q.size() == 0)
        check("result_unexpected", 32'(result_valid), 32'd0);
      else begin
        exp_res = result_q.pop_front();
        check("result_hit_scores", 32'({result_hit, score_local, score_remote}), 32'(exp_res));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk60MHz);
    #1;
  endtask

  task automatic push_result(input bit remote, input bit h);
    if (h && !remote && sl_m < 4'd9) sl_m = sl_m + 4'd1;
    if (h && remote && sr_m < 4'd9) sr_m = sr_m + 4'd1;
    result_q.push_back({h, sl_m, sr_m});
  endtask

  task automatic wait_launch(input int budget);
    for (int i = 0; i < budget && !(throw_flag || in_throw_flag); i++) tick(1);
    if (!(throw_flag || in_throw_flag))
      check("wait_launch", 32'(throw_flag | in_throw_flag), 32'd1);
  endtask

  task automatic wait_end(input int budget);
    for (int i = 0; i < budget && !end_throw; i++) tick(1);
    if (!end_throw) check("wait_end_throw", 32'(end_throw), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) tick(1);
    if (busy) check("wait_idle", 32'(busy), 32'd0);
  endtask

  // Full throw from IDLE: ascend, then land (with optional simultaneous hit), minimal END
  task automatic do_throw(input bit remote, input bit with_hit);
    launch_q.push_back(remote ? 2'b01 : 2'b10);
    push_result(remote, with_hit);
    if (remote) remote_req = 1'b1;
    else local_req = 1'b1;
    wait_launch(5);
    local_req  = 1'b0;
    remote_req = 1'b0;
    ypos = 12'd454;
    tick(3);
    ypos = 12'd780;
    hit  = with_hit;
    tick(1);
    hit  = 1'b0;
    ypos = 12'd768;
    tick(1);
    check("end_min_hold", 32'(end_throw), 32'd1);
    tick(1);
    check("end_release_min", 32'(end_throw), 32'd0);
    wait_idle(20);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; local_req = 1'b0; remote_req = 1'b0; hit = 1'b0; ypos = 12'd768;
    tick(2);
    check("reset_outputs", 32'({throw_flag, in_throw_flag, end_throw, busy, result_valid,
                                result_hit, turn, score_local, score_remote}), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Local throw that lands
    launch_q.push_back(2'b10);
    push_result(1'b0, 1'b0);
    local_req = 1'b1;
    wait_launch(5);
    local_req = 1'b0;
    check("busy_with_launch", 32'(busy), 32'd1);
    ypos = 12'd454;
    tick(1);
    check("launch_width", 32'(throw_flag), 32'd0);
    tick(4);
    ypos = 12'd780;
    wait_end(10);
    tick(4);
    check("end_hold_below_ground", 32'(end_throw), 32'd1);
    ypos = 12'd768;
    tick(1);
    check("end_release", 32'(end_throw), 32'd0);
    check("cooldown_busy", 32'(busy), 32'd1);
    tick(7);
    check("cooldown_len_busy", 32'(busy), 32'd1);
    check("cooldown_len_turn", 32'(turn), 32'd0);
    tick(1);
    check("idle_after_cooldown", 32'(busy), 32'd0);
    check("turn_toggle", 32'(turn), 32'd1);

    // Remote throw hit during ascent
    launch_q.push_back(2'b01);
    push_result(1'b1, 1'b1);
    remote_req = 1'b1;
    wait_launch(5);
    remote_req = 1'b0;
    ypos = 12'd500;
    tick(2);
    hit = 1'b1;
    tick(1);
    hit = 1'b0;
    check("remote_score", 32'(score_remote), 32'd1);
    check("remote_result_hit", 32'(result_hit), 32'd1);
    tick(5);
    check("end_hold_ascent", 32'(end_throw), 32'd1);
    ypos = 12'd768;
    tick(1);
    check("end_release_ascent", 32'(end_throw), 32'd0);
    wait_idle(20);
    check("turn_back_local", 32'(turn), 32'd0);

    // Wrong-turn request ignored, then local throw with hit and landing together
    remote_req = 1'b1;
    tick(10);
    check("wrong_turn_busy", 32'(busy), 32'd0);
    check("wrong_turn_strobe", 32'({throw_flag, in_throw_flag}), 32'd0);
    do_throw(1'b0, 1'b1);
    check("simultaneous_hit", 32'(score_local), 32'd1);

    // Remote timeout
    launch_q.push_back(2'b01);
    push_result(1'b1, 1'b0);
    remote_req = 1'b1;
    wait_launch(5);
    remote_req = 1'b0;
    ypos = 12'd454;
    tick(1000);
    check("timeout_early", 32'(result_valid), 32'd0);
    tick(1);
    check("timeout_exact", 32'(result_valid), 32'd1);
    ypos = 12'd768;
    wait_idle(30);

    // Saturation: 11 more local hits, remote misses in between
    for (int k = 0; k < 11; k++) begin
      do_throw(1'b0, 1'b1);
      do_throw(1'b1, 1'b0);
    end
    check("score_local_sat", 32'(score_local), 32'd9);
    check("score_remote_final", 32'(score_remote), 32'd1);

    // Reset mid-flight
    launch_q.push_back(2'b10);
    local_req = 1'b1;
    wait_launch(5);
    local_req = 1'b0;
    ypos = 12'd454;
    tick(3);
    rst_n = 1'b0;
    #2;
    check("reset_midflight", 32'({throw_flag, in_throw_flag, end_throw, busy, result_valid,
                                  result_hit, score_local, score_remote}), 32'd0);
    check("reset_midflight_turn", 32'(turn), 32'd0);
    tick(2);
    check("reset_held_busy", 32'(busy), 32'd0);
    ypos  = 12'd768;
    sl_m  = 4'd0;
    sr_m  = 4'd0;
    rst_n = 1'b1;
    tick(1);
    do_throw(1'b0, 1'b1);
    check("post_reset_score", 32'(score_local), 32'd1);
    tick(2);
    check("launch_q_drained", 32'(launch_q.size()), 32'd0);
    check("result_q_drained", 32'(result_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/throw_sched.md
# throw_sched

Turn scheduler for the shared projectile trajectory generator. Alternates throws between the local and remote player, issues the one-cycle launch strobes the trajectory generator starts on, and watches the generated vertical position to decide when a throw has ended (landing, hit or timeout). It then drives the trajectory's end strobe, records the result and scores, and enforces a cooldown before the next turn. Sits between the player-input/UART receive logic and the trajectory and collision blocks, all in the 60 MHz domain.

## Interface
- GROUND_Y, 768: vertical position at or beyond which a descending projectile has landed; equals the trajectory generator's idle position.
- TIMEOUT_CYC, 120_000_000: maximum flight length in cycles (2 s); 27-bit counter.
- COOLDOWN_CYC, 6_000_000: idle gap after a throw before a new request is accepted (100 ms); 27-bit counter.
- clk60MHz  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- local_req  in  1  local player throw request, level; honoured only on local turn.
- remote_req  in  1  remote player throw request, level or pulse; honoured only on remote turn.
- hit  in  1  collision detector: projectile overlaps the opponent this cycle.
- ypos_prebuff  in  12  current projectile vertical position from the trajectory generator (unsigned, grows downward).
- throw_flag  out  1  one-cycle launch strobe, local throw.
- in_throw_flag  out  1  one-cycle launch strobe, remote throw.
- end_throw  out  1  end-of-throw request to the trajectory generator, held as below.
- turn  out  1  0 = local player's turn, 1 = remote.
- busy  out  1  high in every state except IDLE.
- result_valid  out  1  one-cycle strobe when a throw is resolved.
- result_hit  out  1  valid with result_valid: 1 = hit, 0 = miss or timeout.
- score_local  out  4  local hits, saturating at 9.
- score_remote  out  4  remote hits, saturating at 9.

## Operation
- States: IDLE, LAUNCH, FLIGHT, END, COOLDOWN.
- IDLE: when turn=0 and local_req=1, or turn=1 and remote_req=1, go to LAUNCH. The non-owner's request is ignored, not queued.
- LAUNCH (1 cycle): assert throw_flag if turn=0, else in_throw_flag. Clear armed flag and flight counter. Go to FLIGHT.
- FLIGHT: flight counter increments each cycle.
  - Set armed when ypos_prebuff < GROUND_Y.
  - hit=1 resolves the throw as a hit. This takes priority over landing and timeout in the same cycle.
  - Else, armed=1 and ypos_prebuff >= GROUND_Y resolves it as a miss.
  - Else, counter = TIMEOUT_CYC-1 resolves it as a miss.
  - On resolution: pulse result_valid with result_hit. On a hit, increment the thrower's score (saturating at 9). Go to END.
- END: end_throw=1. Stay until ypos_prebuff == GROUND_Y and at least 2 cycles have been spent in END. This covers a hit during the ascent, where the generator only honours end_throw once descending. Then go to COOLDOWN.
- COOLDOWN: count COOLDOWN_CYC cycles, toggle turn on the exit edge, go to IDLE.
- hit outside FLIGHT is ignored. Scores never wrap.

## Timing
- Reset values:
  - state IDLE, turn 0.
  - throw_flag, in_throw_flag, end_throw, busy, result_valid, result_hit all 0.
  - Both scores 0, counters 0, armed 0.
- All outputs are registered.
- Request sampled in IDLE at edge N gives the launch strobe high during cycle N+1, exactly 1 cycle wide.
- busy rises with the launch strobe.
- Resolution condition seen at edge M gives result_valid and the score update during cycle M+1. end_throw rises in the same cycle.
- end_throw falls on the first edge where the END exit condition holds.
- busy falls on the cycle IDLE is re-entered.
- turn changes on the same edge that enters IDLE.
- Request held through COOLDOWN: the next launch occurs 1 cycle after entering IDLE, if turn matches.
- Reset asserted mid-flight: immediate return to reset values. Scores are lost.

## Test plan
- Local throw and landing (TIMEOUT_CYC=1000, COOLDOWN_CYC=8). Stimulus: local_req=1 in IDLE; ypos 454 for 5 cycles, then 780. Required response:
  - throw_flag exactly 1 cycle.
  - result_valid with result_hit=0, scores unchanged.
  - end_throw held until ypos=768 is driven.
  - turn=1 after 8 cooldown cycles.
- Remote hit. Stimulus: turn=1, remote_req pulse; hit=1 while ypos=500. Required response:
  - in_throw_flag 1 cycle.
  - score_remote 0→1, result_hit=1.
  - end_throw stays high while ypos<768 and drops after ypos=768.
- Wrong-turn request. Stimulus: turn=0, remote_req=1 held. Required response: no strobe, busy=0. Then local_req=1 gives a local launch.
- Timeout. Stimulus: ypos held at 454 after launch. Required response: result_valid with result_hit=0 exactly 1000 cycles after entering FLIGHT.
- Simultaneous events and saturation. Stimulus: hit=1 and armed landing in the same cycle. Required response:
  - counted as a hit.
  - 12 local hits leave score_local=9.
- Reset mid-flight. Stimulus: rst_n low during FLIGHT. Required response:
  - all outputs 0, turn=0.
  - a new local_req after release launches normally.
